// File: rtl/sr_trace_uart_if.sv
// Trace capture bus: CPU-side record strobe into sr_trace_uart.
//   trace_en    - capture enable; 0 = strobes are ignored
//   trace_valid - one-cycle strobe, record fields valid this cycle
//   trace_pc    - CPU pc
//   trace_instr - CPU instruction
//   trace_data  - selected register value (regData)
interface sr_trace_uart_if;
  logic        trace_en;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic [31:0] trace_data;

  modport master (output trace_en, trace_valid, trace_pc, trace_instr, trace_data);
  modport slave  (input  trace_en, trace_valid, trace_pc, trace_instr, trace_data);
endinterface

// File: rtl/sr_trace_uart.sv
// Hardware trace transmitter: queues {pc, instr, data} records and sends each
// one as the ASCII line "PPPPPPPP IIIIIIII DDDDDDDD\r\n" over an 8N1 UART.
//   clk      - system clock
//   rst_n    - synchronous active-low reset
//   trc      - trace capture bus (slave side)
//   uart_tx  - serial output, idle high
//   busy     - FIFO non-empty or a frame in progress
//   overflow - sticky, at least one record dropped
//   drop_cnt - dropped-record count, saturating
module sr_trace_uart #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DROP_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sr_trace_uart_if.slave    trc,
  output logic              uart_tx,
  output logic              busy,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned REC_W     = 96;
  localparam int unsigned LAST_CHAR = 27;

  // The next character is launched in the last stop-bit cycle of the previous
  // one, so the "send" step has no cycle of its own.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [REC_W-1:0]  shadow_q, shadow_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              tx_on_q, tx_on_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [8:0]        shift_q, shift_d;
  logic              uart_tx_q, uart_tx_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [REC_W-1:0]  mem_q [FIFO_DEPTH];

  logic              req_c, full_c, push_c, pop_c, done_c, launch_c;
  logic [7:0]        launch_byte_c;
  logic [REC_W-1:0]  rec_in_c, head_c;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h57 + 8'(n));
  endfunction

  // ASCII byte at position idx of the line for record rec.
  function automatic logic [7:0] frame_byte(input logic [REC_W-1:0] rec, input logic [4:0] idx);
    logic [31:0] field;
    logic [2:0]  k;
    logic [4:0]  sh;
    logic        is_hex;
    logic [7:0]  ch;
    field  = '0;
    k      = '0;
    is_hex = 1'b0;
    ch     = 8'h20;
    if (idx <= 5'd7) begin
      field = rec[95:64]; k = 3'(idx); is_hex = 1'b1;
    end else if (idx >= 5'd9 && idx <= 5'd16) begin
      field = rec[63:32]; k = 3'(idx - 5'd9); is_hex = 1'b1;
    end else if (idx >= 5'd18 && idx <= 5'd25) begin
      field = rec[31:0]; k = 3'(idx - 5'd18); is_hex = 1'b1;
    end else if (idx == 5'd26) begin
      ch = 8'h0d;
    end else if (idx == 5'd27) begin
      ch = 8'h0a;
    end
    sh = {3'(3'd7 - k), 2'b00};
    if (is_hex) ch = hex_char(4'(field >> sh));
    return ch;
  endfunction

  assign rec_in_c = {trc.trace_pc, trc.trace_instr, trc.trace_data};
  assign head_c   = mem_q[rd_ptr_q];
  assign req_c    = trc.trace_en & trc.trace_valid;
  // Full is taken from the registered count, before any same-cycle pop.
  assign full_c   = (count_q == CW'(FIFO_DEPTH));
  assign push_c   = req_c & ~full_c;

  // Record storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= rec_in_c;
  end

  // Next-state logic: drop accounting, bit shifter, line sequencer, FIFO.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    tx_on_d       = tx_on_q;
    baud_d        = baud_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    uart_tx_d     = uart_tx_q;
    busy_d        = busy_q;
    overflow_d    = overflow_q;
    drop_d        = drop_q;
    pop_c         = 1'b0;
    done_c        = 1'b0;
    launch_c      = 1'b0;
    launch_byte_c = 8'h00;

    if (req_c && full_c) begin
      overflow_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end

    // bit_q 0 = start, 1..8 = data, 9 = stop; done flags the last stop cycle.
    if (tx_on_q) begin
      if (baud_q == BW'(CLK_DIV - 1)) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          done_c    = 1'b1;
          tx_on_d   = 1'b0;
          uart_tx_d = 1'b1;
        end else begin
          bit_d     = bit_q + 4'd1;
          uart_tx_d = shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
        end
      end else begin
        baud_d = baud_q + BW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        pop_c         = 1'b1;
        shadow_d      = head_c;
        idx_d         = '0;
        launch_c      = 1'b1;
        launch_byte_c = frame_byte(head_c, 5'd0);
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (done_c) begin
          if (idx_q != 5'(LAST_CHAR)) begin
            idx_d         = idx_q + 5'd1;
            launch_c      = 1'b1;
            launch_byte_c = frame_byte(shadow_q, idx_q + 5'd1);
          end else if (count_q != '0) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A launch overrides the shifter's own stop-bit completion.
    if (launch_c) begin
      tx_on_d   = 1'b1;
      baud_d    = '0;
      bit_d     = '0;
      shift_d   = {1'b1, launch_byte_c};
      uart_tx_d = 1'b0;
    end

    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    busy_d  = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      shadow_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_on_q    <= 1'b0;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '1;
      uart_tx_q  <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_on_q    <= tx_on_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      uart_tx_q  <= uart_tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign uart_tx  = uart_tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;
endmodule

// File: doc/sr_trace_uart.md
Name: sr_trace_uart

Overview:
- Hardware trace transmitter for the schoolRISCV core. It is the on-chip counterpart of the simulation per-cycle trace print.
- Captures one {pc, instr, regData} record per CPU cycle into a small FIFO.
- Serialises each record as an ASCII hex line over a UART TX pin (8N1), so a host terminal sees the same pc/instr/register stream the simulator prints.
- Sits beside sm_top and is fed from sm_cpu pc/instr and the regAddr/regData debug port.

Parameters:
- CLK_DIV, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 8, record FIFO entries; power of 2, >= 2.
- DROP_W, 8, width of the saturating dropped-record counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous active-low
- trace_en  in  1  capture enable; 0 = ignore trace_valid
- trace_valid  in  1  one-cycle strobe: record inputs valid this cycle
- trace_pc  in  32  CPU pc
- trace_instr  in  32  CPU instruction
- trace_data  in  32  regData (selected register value)
- uart_tx  out  1  serial output, idle high
- busy  out  1  FIFO non-empty or frame in progress
- overflow  out  1  sticky: at least one record dropped
- drop_cnt  out  DROP_W  dropped records, saturating at all-ones

Behaviour:
- Reset is synchronous and active-low: rst_n=0 sampled at a clk edge resets the block.
- Reset values: uart_tx=1, busy=0, overflow=0, drop_cnt=0, FIFO empty, FSM in IDLE, baud counter 0.
- Reset mid-frame abandons the partial frame. uart_tx is 1 from the reset edge onward, and no trailing characters are sent.
- Push: on an edge with trace_en && trace_valid, the 96-bit record {pc, instr, data} is written if the FIFO is not full.
- Full is evaluated before any same-cycle pop. A push into a full FIFO is dropped even if a pop occurs that cycle.
- Drop: overflow is set and stays set until reset. drop_cnt increments and holds at 2^DROP_W-1.
- Frame format: 28 bytes, "PPPPPPPP IIIIIIII DDDDDDDD\r\n".
  - Hex digits are lowercase 0-9a-f, MSB nibble first.
  - Separators are 0x20; the line ends 0x0D then 0x0A.
- FSM states:
  - IDLE: go to LOAD when the FIFO is non-empty.
  - LOAD: one cycle. Pop the FIFO head into the shadow register; set char index to 0.
  - SEND: drive the byte for the current char index into the UART shifter.
  - WAIT: hold until the shifter reports done after the stop bit. Then, if index < 27, increment it and go to SEND.
  - After index 27: go to LOAD if the FIFO is non-empty, else IDLE.
- UART shifter:
  - Each bit lasts exactly CLK_DIV cycles.
  - Order is start(0), d0..d7 LSB first, stop(1).
  - A character is exactly 10*CLK_DIV cycles, and consecutive characters within a frame have no idle gap.
  - Frame to frame, the LOAD/SEND overhead is at most 2 idle-high cycles.
- Latency: a record pushed at edge N into an empty, idle block drives the start bit (uart_tx=0) from edge N+2.
- busy = (FSM != IDLE) || FIFO non-empty. It falls in the cycle after the last stop bit completes with the FIFO empty.
- The FIFO accepts pushes while a frame is transmitting. The shadow register decouples the transmitted record from FIFO contents.
- trace_en=0 does not stop transmission of already-queued records.

Test Plan:
- CLK_DIV=4: push pc=0x00000010, instr=0x00a00513, data=0x0000000a.
  - Decoded bytes must be "00000010 00a00513 0000000a\r\n".
  - First start bit at edge N+2, frame length 1120 cycles.
  - busy then drops; overflow=0.
- Push 3 records on consecutive cycles:
  - Exactly 3 frames in push order.
  - Inter-frame idle gap <= 2 cycles, intra-frame gap 0.
- FIFO_DEPTH=8: push 12 records on 12 consecutive cycles.
  - The first is popped into the shadow register before the FIFO fills.
  - 9 frames are transmitted (records 0..8), drop_cnt=3, overflow=1.
- trace_en=0 with trace_valid pulsed 5 times: no frames, busy=0, drop_cnt=0.
- DROP_W=8: keep the FIFO full and push 300 more records.
  - drop_cnt saturates at 255; overflow stays 1 after the FIFO drains.
- Assert rst_n=0 for 1 cycle mid-character of frame 1 with 4 records queued.
  - uart_tx=1 from the reset edge, busy=0, FIFO empty, overflow=0, drop_cnt=0.
  - No further bytes are sent until a new push.
